// File: rtl/demux_5bit.sv
// 1-to-5 registered demux; one-entry holding register per channel; out_valid[k] rises 1 cycle after the accept.
// in_ready = addressed channel empty or draining this cycle; illegal selects (5..7) are always accepted, then dropped and counted.
module demux_5bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
  output logic [4:0]         out_valid,
  input  logic [4:0]         out_ready,
  output logic [5*WIDTH-1:0] out_data,
  output logic               sel_err,
  output logic [CNT_W-1:0]   err_count
);

  logic [4:0]       sel_oh;
  logic [4:0]       load;
  logic [4:0]       full;
  logic [WIDTH-1:0] hold [5];
  logic             legal;
  logic             ill_acc;

  assign legal   = (in_sel < 3'd5);
  assign ill_acc = in_valid & ~legal;

  always_comb begin
    in_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sel_oh[i] = (in_sel == 3'(i));
      if (sel_oh[i]) in_ready = ~full[i] | out_ready[i];
    end
  end

  assign load      = {5{in_valid & in_ready}} & sel_oh;
  assign out_valid = full;

  for (genvar i = 0; i < 5; i++) begin : g_chan
    assign out_data[i*WIDTH +: WIDTH] = hold[i];

    // A load takes priority over a drain: the old word is delivered and replaced in one edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        full[i] <= 1'b0;
        hold[i] <= '0;
      end else if (load[i]) begin
        full[i] <= 1'b1;
        hold[i] <= in_data;
      end else if (out_ready[i]) begin
        full[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else begin
      sel_err <= ill_acc;
      if (ill_acc && (err_count != {CNT_W{1'b1}})) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_5bit.sv
// Directed and constrained-random checks of demux_5bit; a second instance with CNT_W=2 shows counter saturation.
module tb_demux_5bit;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_sel;
  logic [4:0]   out_valid;
  logic [4:0]   out_ready;
  logic [159:0] out_data;
  logic         sel_err;
  logic [7:0]   err_count;

  logic         s_in_ready;
  logic [4:0]   s_out_valid;
  logic [159:0] s_out_data;
  logic         s_sel_err;
  logic [1:0]   s_err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_5bit #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel_err(sel_err), .err_count(err_count)
  );

  demux_5bit #(.WIDTH(32), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .sel_err(s_sel_err), .err_count(s_err_count)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] chan(input int i);
    return out_data[i*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] d, input logic [4:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  logic [4:0]  m_full;
  logic [31:0] m_data [5];
  int          m_err;
  logic        m_sel_err;
  logic        acc;
  logic        hold_req;
  logic [4:0]  exp_valid;

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 5'b0);
    #10;
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_out_valid", out_valid, 5'b0);
    chk("rst_out_data", out_data, 160'h0);
    chk("rst_sel_err", sel_err, 1'b0);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // 1: single word to channel 2
    drive(1'b1, 3'd2, 32'hA5A5_0001, 5'b00000);
    chk("t1_in_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 3'd0, 32'h0, 5'b00000);
    chk("t1_out_valid", out_valid, 5'b00100);
    chk("t1_out_data", out_data, {32'h0, 32'h0, 32'hA5A5_0001, 32'h0, 32'h0});
    chk("t1_err_count", err_count, 8'd0);

    // 2: backpressure, then simultaneous drain and load
    drive(1'b1, 3'd2, 32'h2, 5'b00000);
    chk("t2_blocked_ready", in_ready, 1'b0);
    tick();
    chk("t2_hold_data", chan(2), 32'hA5A5_0001);
    chk("t2_hold_valid", out_valid, 5'b00100);
    drive(1'b1, 3'd2, 32'h2, 5'b00100);
    chk("t2_unblocked_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 3'd0, 32'h0, 5'b00000);
    chk("t2_reload_valid", out_valid, 5'b00100);
    chk("t2_reload_data", chan(2), 32'h2);

    // 3: stream one word to each channel with all consumers ready
    drive(1'b0, 3'd0, 32'h0, 5'b11111);
    tick();
    chk("t3_drained", out_valid, 5'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3'(k), 32'h10 + 32'(k), 5'b11111);
      chk($sformatf("t3_in_ready_%0d", k), in_ready, 1'b1);
      tick();
      chk($sformatf("t3_valid_%0d", k), out_valid, 5'b1 << k);
      chk($sformatf("t3_data_%0d", k), chan(k), 32'h10 + 32'(k));
    end
    drive(1'b0, 3'd0, 32'h0, 5'b11111);
    tick();
    chk("t3_all_drained", out_valid, 5'b0);

    // 4: illegal selects; channel 3 stays loaded meanwhile
    drive(1'b1, 3'd3, 32'h33, 5'b00000);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd6, 32'hDEAD, 5'b00000);
      chk($sformatf("t4_in_ready_%0d", k), in_ready, 1'b1);
      tick();
      chk($sformatf("t4_sel_err_%0d", k), sel_err, 1'b1);
      chk($sformatf("t4_err_count_%0d", k), err_count, 8'(k + 1));
      chk($sformatf("t4_out_valid_%0d", k), out_valid, 5'b01000);
    end
    chk("t4_small_count3", s_err_count, 2'd3);
    drive(1'b1, 3'd5, 32'hBEEF, 5'b00000);
    tick();
    drive(1'b1, 3'd7, 32'hBEEF, 5'b00000);
    tick();
    chk("t4_err_count5", err_count, 8'd5);
    chk("t4_small_saturated", s_err_count, 2'd3);
    drive(1'b0, 3'd0, 32'h0, 5'b00000);
    tick();
    chk("t4_sel_err_low", sel_err, 1'b0);
    chk("t4_ch3_data", chan(3), 32'h33);

    // 5: asynchronous reset mid-cycle
    drive(1'b1, 3'd1, 32'h11, 5'b00000);
    tick();
    drive(1'b1, 3'd4, 32'h44, 5'b00000);
    tick();
    drive(1'b0, 3'd0, 32'h0, 5'b00000);
    chk("t5_loaded", out_valid, 5'b11010);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_valid", out_valid, 5'b0);
    chk("t5_async_data", out_data, 160'h0);
    chk("t5_async_count", err_count, 8'd0);
    chk("t5_async_small_count", s_err_count, 2'd0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 3'd1, 32'h77, 5'b00000);
    chk("t5_post_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 3'd0, 32'h0, 5'b00000);
    chk("t5_post_valid", out_valid, 5'b00010);
    chk("t5_post_data", chan(1), 32'h77);

    // 6: random traffic against a one-word-per-channel scoreboard
    m_full    = 5'b00010;
    m_data[1] = 32'h77;
    for (int i = 0; i < 5; i++) if (i != 1) m_data[i] = 32'h0;
    m_err     = 0;
    m_sel_err = 1'b0;
    hold_req  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (hold_req)
        drive(1'b1, in_sel, in_data, 5'($urandom_range(0, 31)));
      else
        drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)));
      exp_valid = m_full;
      chk("t6_out_valid", out_valid, exp_valid);
      chk("t6_sel_err", sel_err, m_sel_err);
      acc = (in_sel >= 3'd5) || !m_full[in_sel] || out_ready[in_sel];
      chk("t6_in_ready", in_ready, acc);
      for (int i = 0; i < 5; i++)
        if (m_full[i] && out_ready[i]) chk($sformatf("t6_deliver_ch%0d", i), chan(i), m_data[i]);
      acc       = acc & in_valid;
      hold_req  = in_valid & ~acc;
      m_sel_err = acc && (in_sel >= 3'd5);
      if (m_sel_err) m_err++;
      for (int i = 0; i < 5; i++) begin
        if (acc && in_sel == 3'(i)) begin
          m_full[i] = 1'b1;
          m_data[i] = in_data;
        end else if (out_ready[i]) begin
          m_full[i] = 1'b0;
        end
      end
      tick();
    end
    drive(1'b0, 3'd0, 32'h0, 5'b00000);
    chk("t6_err_count", err_count, 8'(m_err));
    chk("t6_final_valid", out_valid, m_full);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
